// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate stage.
package mac_pkg;

  localparam int IN_W    = 16;
  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    EMIT = 2'd2
  } state_e;

  function automatic int slices_for(input int acc_w);
    return acc_w / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// Plain 8-bit ripple adder with carry in/out, used as the shared slice adder.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/mac_serial_accumulator.sv
// Byte-serial accumulator: sums LEN products through one 8-bit adder, then emits on valid/ready.
// Define MAC_SIGNED_EN for two's-complement products and signed overflow detection.
module mac_serial_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int SLICES = slices_for(ACC_W);
  localparam int K_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int CNT_W  = $clog2(LEN + 1);

  localparam logic [K_W-1:0]   K_LAST  = K_W'(SLICES - 1);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   opnd_q, opnd_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   opnd_ext;
  logic [SLICE_W-1:0] acc_slice;
  logic [SLICE_W-1:0] opnd_slice;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_ovf;
  logic               last_slice;
  logic [CNT_W-1:0]   count_inc;

`ifdef MAC_SIGNED_EN
  logic msb_cin;

  assign opnd_ext  = ACC_W'($signed(in_data));
  // Carry into the top bit recovered from its operands and sum bit.
  assign msb_cin   = acc_slice[SLICE_W-1] ^ opnd_slice[SLICE_W-1] ^ slice_sum[SLICE_W-1];
  assign slice_ovf = slice_cout ^ msb_cin;
`else
  assign opnd_ext  = ACC_W'(in_data);
  assign slice_ovf = slice_cout;
`endif

  assign acc_slice  = acc_q[k_q*SLICE_W +: SLICE_W];
  assign opnd_slice = opnd_q[k_q*SLICE_W +: SLICE_W];
  assign last_slice = (k_q == K_LAST);
  assign count_inc  = count_q + 1'b1;

  adder_8bit u_slice_adder (
    .a    (acc_slice),
    .b    (opnd_slice),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid)   state_d = ADD;
        ADD:     if (last_slice) state_d = (count_inc == CNT_LEN) ? EMIT : IDLE;
        EMIT:    if (out_ready)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == EMIT);
    busy      = (state_q == ADD) || (state_q == EMIT);
    out_data  = out_valid ? acc_q : '0;
    out_ovf   = out_valid & ovf_q;
  end

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    k_d     = k_q;
    carry_d = carry_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      acc_d   = '0;
      opnd_d  = '0;
      k_d     = '0;
      carry_d = 1'b0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opnd_d  = opnd_ext;
            k_d     = '0;
            carry_d = 1'b0;
          end
        end
        ADD: begin
          acc_d[k_q*SLICE_W +: SLICE_W] = slice_sum;
          carry_d = slice_cout;
          k_d     = k_q + 1'b1;
          if (last_slice) begin
            k_d     = '0;
            ovf_d   = ovf_q | slice_ovf;
            count_d = count_inc;
          end
        end
        EMIT: begin
          if (out_ready) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
